// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: resolves unconditional jumps, holds fetch while
// a conditional branch resolves in the ALU, inserts one-cycle load-use
// stalls and keeps a saturating count of taken redirects.
// All outputs are registered; the decision on ins sampled at edge k is
// visible just after edge k.
module fetch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [4:0]  OP_J         = 5'b00010,
  parameter logic [4:0]  OP_BEQ       = 5'b00100,
  parameter logic [4:0]  OP_BNE       = 5'b00101,
  parameter logic [4:0]  OP_LW        = 5'b10011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [16:0] current_address,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic [15:0] jump_loc,
  output logic        pc_mux_sel,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_BR_WAIT,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } ins_fields_t;

  // Redirect cycle itself counts as the first flush cycle.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  lw_dest_q, lw_dest_d;
  logic [15:0] target_q, target_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [15:0] jump_loc_d;
  logic        pc_sel_d;
  logic        stall_d;
  logic        flush_d;
  logic [15:0] cnt_d;
  logic [15:0] cnt_inc;
  logic        hazard;
  ins_fields_t f;

  // Bit 16 of the fetch address does not take part in branch targets.
  logic unused_addr_msb;
  assign unused_addr_msb = current_address[16];

  assign f.opcode = ins[31:27];
  assign f.rd     = ins[26:22];
  assign f.rs     = ins[21:17];
  assign f.rt     = ins[16:12];
  assign f.imm    = ins[15:0];

  assign hazard  = (lw_dest_q != 5'd0) && ((f.rs == lw_dest_q) || (f.rt == lw_dest_q));
  assign cnt_inc = (redirect_cnt == 16'hFFFF) ? redirect_cnt : redirect_cnt + 16'd1;

  // Next-state and next-output decision; idle outputs are the defaults.
  always_comb begin
    state_d    = state_q;
    lw_dest_d  = lw_dest_q;
    target_d   = target_q;
    fcnt_d     = fcnt_q;
    jump_loc_d = jump_loc;
    pc_sel_d   = 1'b1;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    cnt_d      = redirect_cnt;
    case (state_q)
      S_RUN: begin
        if (hazard) begin
          // Hold the consumer for one cycle; it is re-decoded afterwards.
          stall_d   = 1'b1;
          lw_dest_d = 5'd0;
          state_d   = S_LU_STALL;
        end else if (f.opcode == OP_J) begin
          jump_loc_d = f.imm;
          pc_sel_d   = 1'b0;
          flush_d    = 1'b1;
          cnt_d      = cnt_inc;
          lw_dest_d  = 5'd0;
          fcnt_d     = FLUSH_INIT;
          state_d    = S_FLUSH;
        end else if ((f.opcode == OP_BEQ) || (f.opcode == OP_BNE)) begin
          target_d  = current_address[15:0] + 16'd1 + f.imm;
          stall_d   = 1'b1;
          lw_dest_d = 5'd0;
          state_d   = S_BR_WAIT;
        end else if (f.opcode == OP_LW) begin
          lw_dest_d = f.rd;
        end else begin
          lw_dest_d = 5'd0;
        end
      end
      S_LU_STALL: begin
        state_d = S_RUN;
      end
      S_BR_WAIT: begin
        if (br_valid) begin
          if (br_taken) begin
            jump_loc_d = target_q;
            pc_sel_d   = 1'b0;
            flush_d    = 1'b1;
            cnt_d      = cnt_inc;
            fcnt_d     = FLUSH_INIT;
            state_d    = S_FLUSH;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          stall_d = 1'b1;
        end
      end
      S_FLUSH: begin
        lw_dest_d = 5'd0;
        if (fcnt_q != 3'd0) begin
          flush_d = 1'b1;
          fcnt_d  = fcnt_q - 3'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State and registered outputs; reset aborts any branch wait or flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      lw_dest_q    <= 5'd0;
      target_q     <= 16'd0;
      fcnt_q       <= 3'd0;
      jump_loc     <= 16'd0;
      pc_mux_sel   <= 1'b1;
      stall        <= 1'b0;
      stall_pm     <= 1'b0;
      flush        <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      state_q      <= state_d;
      lw_dest_q    <= lw_dest_d;
      target_q     <= target_d;
      fcnt_q       <= fcnt_d;
      jump_loc     <= jump_loc_d;
      pc_mux_sel   <= pc_sel_d;
      stall        <= stall_d;
      stall_pm     <= stall_d;
      flush        <= flush_d;
      redirect_cnt <= cnt_d;
    end
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Control end of the instruction-fetch interface. Consumes the fetched instruction and its address from PROGRAM_MEMORY.
- Drives PROGRAM_MEMORY's redirect/hold inputs: jump_loc, pc_mux_sel, stall, stall_pm. Also drives a flush to the decode stage.
- Resolves unconditional jumps locally, holds fetch while a conditional branch resolves in the ALU, and inserts one-cycle load-use stalls.
- Keeps a saturating redirect counter for bring-up.

Parameters:
- FLUSH_CYCLES, 1: cycles flush stays high after a redirect (1..7).
- OP_J, 5'b00010: unconditional jump opcode.
- OP_BEQ, 5'b00100: branch-equal opcode.
- OP_BNE, 5'b00101: branch-not-equal opcode.
- OP_LW, 5'b10011: load-word opcode.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ins  in  32  instruction from PROGRAM_MEMORY.
- current_address  in  17  address of ins.
- br_valid  in  1  ALU branch outcome valid this cycle.
- br_taken  in  1  ALU branch outcome, qualified by br_valid.
- jump_loc  out  16  redirect target to PROGRAM_MEMORY.
- pc_mux_sel  out  1  1 = sequential PC+1; 0 = load jump_loc.
- stall  out  1  freeze PC.
- stall_pm  out  1  hold the ins register in PROGRAM_MEMORY.
- flush  out  1  decode must treat its current instruction as NOP.
- redirect_cnt  out  16  count of taken redirects, saturating.

Behaviour:
- Fields: opcode = ins[31:27], rd = ins[26:22], rs = ins[21:17], rt = ins[16:12], imm = ins[15:0].
- Timing: all outputs are registered. The decision made on the ins sampled at edge k is visible after edge k.
- Reset (reset=0, asynchronous):
  - Outputs: pc_mux_sel=1, jump_loc=0, stall=0, stall_pm=0, flush=0, redirect_cnt=0.
  - Internal: state=RUN, lw_dest=0, flush counter=0.
  - Reset asserted mid-BR_WAIT or mid-FLUSH aborts that operation immediately.
- States: RUN, LU_STALL, BR_WAIT, FLUSH.
- RUN, priority order:
  1. Load-use hazard: lw_dest != 0 and (rs == lw_dest or rt == lw_dest). Action: stall=1, stall_pm=1, clear lw_dest, go LU_STALL. The current ins is not decoded this cycle.
  2. opcode == OP_J: jump_loc = imm, pc_mux_sel=0 for exactly one cycle, flush=1, redirect_cnt+1, go FLUSH.
  3. opcode == OP_BEQ or OP_BNE: latch target = (current_address[15:0] + 1 + imm) mod 2^16, ignoring current_address[16]. Drive stall=1, stall_pm=1, go BR_WAIT.
  4. opcode == OP_LW: lw_dest = rd. Stay in RUN with outputs idle.
  5. Any other opcode: lw_dest = 0, outputs idle.
- LU_STALL: lasts one cycle. Release stall and stall_pm, return to RUN. The held ins is then re-decoded with lw_dest=0, so a dependent branch after a load costs 1 stall cycle, then normal branch handling.
- BR_WAIT:
  - stall and stall_pm stay high; br_valid is sampled only in this state.
  - br_valid & br_taken: jump_loc = target, pc_mux_sel=0 for one cycle, stall=0, stall_pm=0, flush=1, redirect_cnt+1, go FLUSH.
  - br_valid & !br_taken: release stall and stall_pm, return to RUN. No flush.
  - br_valid low: wait indefinitely. No timeout.
- FLUSH:
  - flush=1 for FLUSH_CYCLES cycles total, counted from the redirect cycle.
  - pc_mux_sel=1 after the first cycle. ins is ignored and lw_dest=0.
  - Return to RUN when done.
- redirect_cnt: increments on each taken redirect and saturates at 16'hFFFF (no wrap).
- stall and stall_pm are always equal in this block.
- pc_mux_sel=0 is never asserted together with stall=1.

Test Plan:
- Reset check: hold reset=0 across 3 clocks while ins=J 0x0008 -> outputs stay at reset values. Release reset; next edge -> jump_loc=0x0008, pc_mux_sel=0, flush=1, redirect_cnt=1. One cycle later -> pc_mux_sel=1, flush=0.
- Branch not taken: BEQ at current_address=0x0010, imm=0x0004 -> stall=stall_pm=1. br_valid=0 for 3 cycles, then br_valid=1 with br_taken=0 -> stall drops the next cycle, no flush, redirect_cnt unchanged.
- Branch taken with wrap: BNE at 0x1FFFE (bit 16 ignored), imm=0x0003 -> after br_taken, jump_loc=0x0002, pc_mux_sel=0, flush=1.
- Load-use: LW rd=5, then ADD rs=5 -> exactly one cycle of stall=stall_pm=1, then RUN. Repeat with rd=0 -> no stall.
- Load then dependent branch: LW rd=3, then BEQ rt=3 -> 1 LU_STALL cycle, then BR_WAIT. Assert reset mid-BR_WAIT -> stall=0 immediately, without waiting for a clock edge.
- Saturation: preload via 65535 jumps (or force the counter) -> one more jump leaves redirect_cnt=0xFFFF. Also run with FLUSH_CYCLES=3 -> flush high for 3 cycles per redirect.
